// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered into the ALU and the result is returned on a tagged response channel.
module alu_arbiter #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [3:0]   req0_opcode,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [3:0]   req1_opcode,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic [3:0]   alu_opcode,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   input  logic [N-1:0] alu_result,
   input  logic [3:0]   alu_flags,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_result,
   output logic [3:0]   rsp_flags
);

   // state | meaning
   // IDLE  | no operation held
   // EXEC  | ALU operand registers valid, result settles this cycle
   // RESP  | response held on rsp_* until the consumer takes it
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state, state_nxt;
   logic   last_grant;
   logic   cur_id;
   logic   grant;
   logic   window;
   logic   accept;

   always_comb begin
      window = (state == IDLE) || ((state == RESP) && rsp_ready);

      // With nobody asking, point at the requester that would win a tie.
      if (req0_valid && req1_valid) grant = ~last_grant;
      else if (req1_valid)          grant = 1'b1;
      else if (req0_valid)          grant = 1'b0;
      else                          grant = ~last_grant;

      req0_ready = window && !grant;
      req1_ready = window && grant;
      accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = accept ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cur_id     <= 1'b0;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            alu_opcode <= grant ? req1_opcode : req0_opcode;
            alu_a      <= grant ? req1_a : req0_a;
            alu_b      <= grant ? req1_b : req0_b;
            cur_id     <= grant;
            last_grant <= grant;
         end
         if (state == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= cur_id;
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
         end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked against a transaction-level occupancy model.
module tb_alu_arbiter;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]   req0_opcode, req1_opcode, alu_opcode, alu_flags, rsp_flags;
   logic [N-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
   logic         rsp_valid, rsp_ready, rsp_id;

   always #5 clk = ~clk;

   alu_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags)
   );

   // Stand-in ALU: returns {C,O,N,Z, result}; unknown opcodes pass A through.
   function automatic logic [N+3:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
      logic [N:0]   w;
      logic [N-1:0] r;
      logic         c, o;
      w = '0; c = 1'b0; o = 1'b0;
      case (op)
         4'd0: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[N-1:0];
            c = w[N];
            o = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
         end
         4'd1: begin
            r = a - b;
            c = (a < b);
            o = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
         end
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a ^ b;
         default: r = a;
      endcase
      return {c, o, r[N-1], (r == '0), r};
   endfunction

   always_comb {alu_flags, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

   typedef struct {
      logic         rst;
      logic         v0;
      logic [3:0]   op0;
      logic [N-1:0] a0, b0;
      logic         v1;
      logic [3:0]   op1;
      logic [N-1:0] a1, b1;
      logic         rr;
   } stim_t;

   typedef struct {
      stim_t        s;
      logic         ck_rdy;
      logic         e_r0, e_r1, e_rv, e_id;
      logic [N-1:0] e_res;
      logic [3:0]   e_flg;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: an op occupies the block from accept until its response is consumed;
   // m_age counts cycles since accept (0 = ALU cycle, >=1 = response visible).
   logic         m_busy, m_last, m_id;
   int           m_age;
   logic [3:0]   m_op, m_flg;
   logic [N-1:0] m_a, m_b, m_res;
   int           g_acc, g_rsp;

   task automatic model_reset();
      m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_id = 1'b0;
      m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_flg = '0;
   endtask

   task automatic step_begin(input stim_t s);
      logic          exp_rv, win, g, acc;
      logic [N+3:0]  fr;
      rst = s.rst; rsp_ready = s.rr;
      req0_valid = s.v0; req0_opcode = s.op0; req0_a = s.a0; req0_b = s.b0;
      req1_valid = s.v1; req1_opcode = s.op1; req1_a = s.a1; req1_b = s.b1;
      #1;
      exp_rv = m_busy && (m_age >= 1);
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
         chk("rsp_id", 64'(rsp_id), 64'(m_id));
         chk("rsp_result", 64'(rsp_result), 64'(m_res));
         chk("rsp_flags", 64'(rsp_flags), 64'(m_flg));
      end
      chk("alu_opcode", 64'(alu_opcode), 64'(m_op));
      chk("alu_a", 64'(alu_a), 64'(m_a));
      chk("alu_b", 64'(alu_b), 64'(m_b));
      chk("one_ready", 64'(req0_ready && req1_ready), 64'(1'b0));
      win = !m_busy || (exp_rv && s.rr);
      g   = (s.v0 && s.v1) ? !m_last : s.v1;
      if (s.v0 || s.v1) begin
         chk("req0_ready", 64'(req0_ready), 64'(win && !g));
         chk("req1_ready", 64'(req1_ready), 64'(win && g));
      end
      g_acc = (req0_valid && req0_ready) ? 0 : ((req1_valid && req1_ready) ? 1 : -1);
      g_rsp = (rsp_valid && rsp_ready) ? int'(rsp_id) : -1;
      acc = win && (s.v0 || s.v1);
      if (s.rst) model_reset();
      else if (acc) begin
         m_busy = 1'b1; m_age = 0; m_last = g; m_id = g;
         m_op = g ? s.op1 : s.op0;
         m_a  = g ? s.a1 : s.a0;
         m_b  = g ? s.b1 : s.b0;
         fr   = alu_fn(m_op, m_a, m_b);
         m_flg = fr[N+3:N];
         m_res = fr[N-1:0];
      end else if (exp_rv && s.rr) m_busy = 1'b0;
      else if (m_busy) m_age++;
   endtask

   task automatic cyc(input stim_t s);
      step_begin(s);
      @(negedge clk);
   endtask

   function automatic stim_t mk(input logic v0, input logic [3:0] op0, input logic [N-1:0] a0,
                                input logic [N-1:0] b0, input logic v1, input logic [3:0] op1,
                                input logic [N-1:0] a1, input logic [N-1:0] b1, input logic rr);
      stim_t s;
      s.rst = 1'b0; s.rr = rr;
      s.v0 = v0; s.op0 = op0; s.a0 = a0; s.b0 = b0;
      s.v1 = v1; s.op1 = op1; s.a1 = a1; s.b1 = b1;
      return s;
   endfunction

   function automatic stim_t idle_s(input logic rr);
      return mk(1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0, rr);
   endfunction

   function automatic stim_t rst_s();
      stim_t s;
      s = idle_s(1'b0);
      s.rst = 1'b1;
      return s;
   endfunction

   function automatic logic [N-1:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return '1;
         default: return N'($urandom);
      endcase
   endfunction

   function automatic stim_t both(input logic rr);
      return mk(1'b1, 4'($urandom), rnd_operand(), rnd_operand(),
                1'b1, 4'($urandom), rnd_operand(), rnd_operand(), rr);
   endfunction

   function automatic vec_t vec(input stim_t s, input logic ck_rdy, input logic e_r0,
                                input logic e_r1, input logic e_rv, input logic e_id,
                                input logic [N-1:0] e_res, input logic [3:0] e_flg);
      vec_t v;
      v.s = s; v.ck_rdy = ck_rdy; v.e_r0 = e_r0; v.e_r1 = e_r1;
      v.e_rv = e_rv; v.e_id = e_id; v.e_res = e_res; v.e_flg = e_flg;
      return v;
   endfunction

   initial begin
      vec_t  tv[11];
      stim_t s;
      int    qg[$], qr[$];
      int    n;
      logic          h_id;
      logic [N-1:0]  h_res;
      logic [3:0]    h_flg;

      // flags are {C,O,N,Z}
      tv[0]  = vec(mk(1'b1, 4'd0, 32'd5, 32'd3, 1'b0, 4'd0, '0, '0, 1'b1),
                   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 4'b0000);
      tv[1]  = vec(idle_s(1'b1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'b0000);
      tv[2]  = vec(idle_s(1'b1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd8, 4'b0000);
      tv[3]  = vec(mk(1'b0, 4'd0, '0, '0, 1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1),
                   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 4'b0000);
      tv[4]  = vec(idle_s(1'b1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'b0000);
      tv[5]  = vec(mk(1'b1, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0, 1'b1),
                   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b0110);
      tv[6]  = vec(idle_s(1'b1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'b0000);
      tv[7]  = vec(idle_s(1'b1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 4'b0001);
      tv[8]  = vec(mk(1'b0, 4'd0, '0, '0, 1'b1, 4'hE, 32'h1234, 32'd5, 1'b1),
                   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 4'b0000);
      tv[9]  = vec(idle_s(1'b1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'b0000);
      tv[10] = vec(idle_s(1'b1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1234, 4'b0000);

      s = rst_s();
      rst = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_opcode = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0;
      repeat (2) @(negedge clk);
      model_reset();

      for (int i = 0; i < 11; i++) begin
         step_begin(tv[i].s);
         if (tv[i].ck_rdy) begin
            chk($sformatf("tv%0d_req0_ready", i), 64'(req0_ready), 64'(tv[i].e_r0));
            chk($sformatf("tv%0d_req1_ready", i), 64'(req1_ready), 64'(tv[i].e_r1));
         end
         chk($sformatf("tv%0d_rsp_valid", i), 64'(rsp_valid), 64'(tv[i].e_rv));
         if (tv[i].e_rv) begin
            chk($sformatf("tv%0d_rsp_id", i), 64'(rsp_id), 64'(tv[i].e_id));
            chk($sformatf("tv%0d_rsp_result", i), 64'(rsp_result), 64'(tv[i].e_res));
            chk($sformatf("tv%0d_rsp_flags", i), 64'(rsp_flags), 64'(tv[i].e_flg));
         end
         @(negedge clk);
      end

      // Tie: both requesters always valid, grants alternate starting with 0.
      cyc(rst_s());
      for (int i = 0; i < 8; i++) begin
         step_begin(both(1'b1));
         if (g_acc >= 0) qg.push_back(g_acc);
         if (g_rsp >= 0) qr.push_back(g_rsp);
         @(negedge clk);
      end
      chk("tie_grant_count", 64'(qg.size()), 64'(4));
      chk("tie_rsp_count", 64'(qr.size()), 64'(3));
      for (int k = 0; k < qg.size() && k < 4; k++)
         chk($sformatf("tie_grant%0d", k), 64'(qg[k]), 64'(k % 2));
      for (int k = 0; k < qr.size() && k < 3; k++)
         chk($sformatf("tie_rsp%0d", k), 64'(qr[k]), 64'(k % 2));

      // Backpressure: response held five cycles, then released with a new accept.
      cyc(rst_s());
      step_begin(both(1'b1));
      chk("bp_first_grant", 64'(g_acc), 64'(0));
      @(negedge clk);
      cyc(both(1'b1));
      h_id = 1'b0; h_res = '0; h_flg = '0;
      for (int i = 0; i < 5; i++) begin
         step_begin(both(1'b0));
         if (i == 0) begin
            h_id = rsp_id; h_res = rsp_result; h_flg = rsp_flags;
         end else begin
            chk("bp_id_stable", 64'(rsp_id), 64'(h_id));
            chk("bp_result_stable", 64'(rsp_result), 64'(h_res));
            chk("bp_flags_stable", 64'(rsp_flags), 64'(h_flg));
         end
         chk("bp_rsp_valid", 64'(rsp_valid), 64'(1'b1));
         chk("bp_ready_low", 64'({req0_ready, req1_ready}), 64'(2'b00));
         @(negedge clk);
      end
      step_begin(both(1'b1));
      chk("bp_release_accept", 64'(g_acc), 64'(1));
      @(negedge clk);

      // Reset during EXEC, then during RESP.
      for (int r = 0; r < 2; r++) begin
         cyc(rst_s());
         cyc(mk(1'b1, 4'd0, 32'h55, 32'h66, 1'b0, 4'd0, '0, '0, 1'b1));
         if (r == 1) cyc(idle_s(1'b0));
         cyc(rst_s());
         step_begin(both(1'b1));
         chk($sformatf("rst%0d_rsp_valid", r), 64'(rsp_valid), 64'(1'b0));
         chk($sformatf("rst%0d_alu_a", r), 64'(alu_a), 64'(0));
         chk($sformatf("rst%0d_alu_b", r), 64'(alu_b), 64'(0));
         chk($sformatf("rst%0d_first_grant", r), 64'(g_acc), 64'(0));
         @(negedge clk);
      end

      // Only requester 1 streaming.
      cyc(rst_s());
      n = 0;
      for (int i = 0; i < 9; i++) begin
         step_begin(mk(1'b0, 4'd0, '0, '0, 1'b1, 4'($urandom), rnd_operand(), rnd_operand(), 1'b1));
         if (g_rsp >= 0) begin
            n++;
            chk("stream_id", 64'(g_rsp), 64'(1));
         end
         @(negedge clk);
      end
      chk("stream_count", 64'(n), 64'(4));

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         s = mk(1'($urandom), 4'($urandom), rnd_operand(), rnd_operand(),
                1'($urandom), 4'($urandom), rnd_operand(), rnd_operand(),
                $urandom_range(0, 3) != 0);
         s.rst = ($urandom_range(0, 59) == 0);
         cyc(s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters (e.g. the execute stage and an address/compare unit).
- Accepts operations over valid/ready handshakes and arbitrates round-robin.
- Drives registered opcode/operands into the ALU and captures result + flags.
- Returns them on a valid/ready response channel tagged with the requester ID.

Parameters:
- N, 32, datapath width; must match the ALU's N.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle (when valid)
- req0_opcode  in  4  requester 0 ALU opcode
- req0_a  in  N  requester 0 operand A
- req0_b  in  N  requester 0 operand B
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b  same as requester 0, for requester 1
- alu_opcode  out  4  to ALU opcode, registered
- alu_a  out  N  to ALU operandA, registered
- alu_b  out  N  to ALU operandB, registered
- alu_result  in  N  from ALU result
- alu_flags  in  4  from ALU {C_Flag,O_Flag,N_Flag,Z_Flag}
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the response
- rsp_result  out  N  captured ALU result
- rsp_flags  out  4  captured {C,O,N,Z}

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_flags=0.
  - alu_opcode=0, alu_a=0, alu_b=0; last_grant=1, so requester 0 wins the first tie.
  - Reset mid-operation discards any in-flight op and pending response; no response is ever emitted for it.
- States:
  - IDLE: no op held.
  - EXEC: ALU operand registers valid; ALU result settles this cycle.
  - RESP: response held on rsp_*.
- Accept window: open = (state==IDLE) or (state==RESP and rsp_ready).
- Grant (combinational, only while window open):
  - Only one requester valid -> it is granted.
  - Both valid -> grant the requester != last_grant.
  - reqX_ready = window open and grant==X. At most one ready high per cycle.
  - Ready never depends on the requester's own valid beyond grant selection.
- On accept (reqX_valid & reqX_ready):
  - Load alu_opcode/alu_a/alu_b from requester X; cur_id<=X; last_grant<=X; state<=EXEC.
- EXEC (exactly one cycle):
  - Capture rsp_result<=alu_result, rsp_flags<=alu_flags, rsp_id<=cur_id; rsp_valid<=1; state<=RESP.
  - No accept in EXEC.
- RESP: rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - rsp_ready=1 with no accept -> rsp_valid<=0, state<=IDLE.
  - rsp_ready=1 with a simultaneous accept -> rsp_valid<=0, state<=EXEC (back-to-back, no IDLE bubble).
- ALU operand registers hold their last values outside EXEC; they change only on accept.
- Latency: accept at edge t -> EXEC in cycle t+1 -> rsp_valid=1 from cycle t+2.
- Throughput: 1 op per 2 cycles with rsp_ready held high.
- Arithmetic and flags: block is opcode-agnostic; opcode and flags pass through unmodified. No width conversion.
- Requester valid dropped without a handshake: no effect, nothing is latched.
- Any 4-bit opcode is forwarded, including undefined encodings.

Test Plan:
- Single op: after reset, req0 {opcode=0, a=5, b=3} held valid, rsp_ready=1.
  -> req0_ready=1 in cycle 1, rsp_valid=1 in cycle 3, rsp_id=0, rsp_result/flags equal the ALU's output for 5 op 3, rsp_valid low the next cycle.
- Tie and round-robin: req0 and req1 both valid continuously, rsp_ready=1.
  -> grants alternate 0,1,0,1 starting with 0; rsp_id sequence 0,1,0,1; one response every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises, then 1.
  -> rsp_result/rsp_flags/rsp_id stable all 5 cycles; both ready outputs 0; the next op is accepted in the rsp_ready=1 cycle.
- Flag capture: operands A=32'h7FFFFFFF, B=1 with the add opcode.
  -> rsp_flags O=1, N=1, Z=0, C=0. A=B=0 with the same opcode -> Z=1.
- Reset mid-op: assert rst during EXEC and again during RESP.
  -> next cycle rsp_valid=0, state IDLE, alu_a/alu_b=0; first accept after reset goes to req0 if both are valid.
- Single requester streaming: only req1 valid for 4 ops, rsp_ready=1.
  -> 4 responses with rsp_id=1, no starvation or stall from the last_grant state.
